// File: rtl/c3lib_ckinv_pol_ctl_pkg.sv
// Shared types and helpers for the c3lib clock-switch controllers.
package c3lib_ckctl_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        GATE   = 3'd2,
        SWITCH = 3'd3,
        UNGATE = 3'd4
    } ckpol_state_e;

    // Counter width able to hold (max(a,b,c) - 1), never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/c3lib_ckinv_pol_ctl_if.sv
// Control/status bundle between a polarity requester and the polarity controller.
interface c3lib_ckinv_pol_ctl_if;

    logic tgt_inv;
    logic sw_hold;
    logic ck_en;
    logic ck_inv_sel;
    logic busy;
    logic sw_done;

    modport master (
        output tgt_inv, sw_hold,
        input  ck_en, ck_inv_sel, busy, sw_done
    );

    modport slave (
        input  tgt_inv, sw_hold,
        output ck_en, ck_inv_sel, busy, sw_done
    );

endinterface

// File: rtl/c3lib_ckinv_pol_ctl_dcnt.sv
// Loadable down-counter with a zero flag; saturates at zero.
module c3lib_ckctl_dcnt #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/c3lib_ckinv_pol_ctl.sv
// Glitch-free polarity sequencer for a true/inverted clock pair: gate off,
// flip the mux select, let the path settle, then re-enable the clock gate.
//
// state  | meaning
// -------+-----------------------------------------------------------
// INIT   | post-reset wait, clock gated, UNGATE_CYC cycles
// IDLE   | clock running, watching for a polarity request
// GATE   | clock gated, select still old, GATE_CYC cycles
// SWITCH | select flipped, clock still gated, SETTLE_CYC cycles
// UNGATE | clock re-enabled, still busy, UNGATE_CYC cycles
module c3lib_ckinv_pol_ctl
    import c3lib_ckctl_pkg::*;
#(
    parameter int   GATE_CYC   = 4,
    parameter int   SETTLE_CYC = 2,
    parameter int   UNGATE_CYC = 4,
    parameter logic RST_INV    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    c3lib_ckinv_pol_ctl_if.slave  bus
);

    localparam int CNT_W = cnt_width(GATE_CYC, SETTLE_CYC, UNGATE_CYC);

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] UNGATE_LD = CNT_W'(UNGATE_CYC - 1);

    ckpol_state_e     state, state_nxt;
    logic             ck_en_q, ck_en_nxt;
    logic             sel_q, sel_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             tgt_lat, tgt_lat_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             start;

    assign start   = (bus.tgt_inv != sel_q) && !bus.sw_hold;
    assign cnt_dec = (state != IDLE);

    c3lib_ckctl_dcnt #(
        .W       (CNT_W),
        .RST_VAL (UNGATE_LD)
    ) u_dcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State and registered outputs; reset gates the clock off immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            ck_en_q <= 1'b0;
            sel_q   <= RST_INV;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tgt_lat <= RST_INV;
        end else begin
            state   <= state_nxt;
            ck_en_q <= ck_en_nxt;
            sel_q   <= sel_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            tgt_lat <= tgt_lat_nxt;
        end
    end

    // Next-state: each timed state exits when its counter reaches zero.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (cnt_zero) state_nxt = IDLE;
            IDLE:    if (start)    state_nxt = GATE;
            GATE:    if (cnt_zero) state_nxt = SWITCH;
            SWITCH:  if (cnt_zero) state_nxt = UNGATE;
            UNGATE:  if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Output next-values and counter loads; select and enable never move together.
    always_comb begin
        ck_en_nxt   = ck_en_q;
        sel_nxt     = sel_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        tgt_lat_nxt = tgt_lat;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        case (state)
            INIT: begin
                if (cnt_zero) begin
                    ck_en_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            IDLE: begin
                if (start) begin
                    tgt_lat_nxt = bus.tgt_inv;
                    ck_en_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = GATE_LD;
                end
            end
            GATE: begin
                if (cnt_zero) begin
                    sel_nxt  = tgt_lat;
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                end
            end
            SWITCH: begin
                if (cnt_zero) begin
                    ck_en_nxt = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = UNGATE_LD;
                end
            end
            UNGATE: begin
                if (cnt_zero) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                ck_en_nxt = 1'b0;
                busy_nxt  = 1'b1;
                cnt_load  = 1'b1;
                cnt_val   = UNGATE_LD;
            end
        endcase
    end

    assign bus.ck_en      = ck_en_q;
    assign bus.ck_inv_sel = sel_q;
    assign bus.busy       = busy_q;
    assign bus.sw_done    = done_q;

endmodule

// File: tb/tb_c3lib_ckinv_pol_ctl.sv
// Directed bench for the clock polarity sequencer: default timing on dut_a,
// all-ones timing on dut_b, plus a running select-vs-enable ordering monitor.
module tb_c3lib_ckinv_pol_ctl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    always #5 clk = ~clk;

    c3lib_ckinv_pol_ctl_if bus_a ();
    c3lib_ckinv_pol_ctl_if bus_b ();

    c3lib_ckinv_pol_ctl dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    c3lib_ckinv_pol_ctl #(
        .GATE_CYC   (1),
        .SETTLE_CYC (1),
        .UNGATE_CYC (1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // {ck_en, ck_inv_sel, busy, sw_done}
    function automatic logic [3:0] st_a();
        return {bus_a.ck_en, bus_a.ck_inv_sel, bus_a.busy, bus_a.sw_done};
    endfunction

    function automatic logic [3:0] st_b();
        return {bus_b.ck_en, bus_b.ck_inv_sel, bus_b.busy, bus_b.sw_done};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: observed en/sel/busy/done=%b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: observed %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Walks dut_a through one full switch starting on the next edge.
    task automatic run_switch(input string tag, input logic from_v, input logic to_v,
                              input bit mid_hold, input bit mid_tgt, input logic mid_val);
        int s;
        logic [3:0] exp;
        s = edge_n + 1;
        for (int e = s; e <= s + 10; e++) begin
            step();
            if (e == s + 1) begin
                if (mid_hold) bus_a.sw_hold = 1'b1;
                if (mid_tgt)  bus_a.tgt_inv = mid_val;
            end
            exp = {(e >= s + 6), ((e >= s + 4) ? to_v : from_v), (e < s + 10), (e == s + 10)};
            chk(tag, st_a(), exp);
        end
    endtask

    // Ordering monitor: the select may only move while the clock has been gated long enough.
    logic pa_sel, pb_sel, prst = 1'b0;
    int   low_a = 0, low_b = 0, done_a = 0;

    always @(negedge clk) begin
        if (rst_n && prst) begin
            if (bus_a.ck_inv_sel !== pa_sel) begin
                checks++;
                assert (bus_a.ck_en === 1'b0 && low_a >= 4) else begin
                    errors++;
                    $error("FAIL sel_order_a: observed ck_en=%b low_run=%0d expected ck_en=0 low_run>=4", bus_a.ck_en, low_a);
                end
            end
            if (bus_b.ck_inv_sel !== pb_sel) begin
                checks++;
                assert (bus_b.ck_en === 1'b0 && low_b >= 1) else begin
                    errors++;
                    $error("FAIL sel_order_b: observed ck_en=%b low_run=%0d expected ck_en=0 low_run>=1", bus_b.ck_en, low_b);
                end
            end
            if (bus_a.sw_done === 1'b1) done_a <= done_a + 1;
        end
        low_a  <= (bus_a.ck_en === 1'b0) ? low_a + 1 : 0;
        low_b  <= (bus_b.ck_en === 1'b0) ? low_b + 1 : 0;
        pa_sel <= bus_a.ck_inv_sel;
        pb_sel <= bus_b.ck_inv_sel;
        prst   <= rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.tgt_inv = 1'b0;
        bus_a.sw_hold = 1'b0;
        bus_b.tgt_inv = 1'b0;
        bus_b.sw_hold = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", st_a(), 4'b0010);
        chk("rst_b", st_b(), 4'b0010);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        edge_n = 0;

        // INIT: dut_a enables on edge 4, dut_b on edge 1
        step();
        chk("init_a_e1", st_a(), 4'b0010);
        chk("init_b_e1", st_b(), 4'b1000);
        step();
        step();
        chk("init_a_e3", st_a(), 4'b0010);
        bus_b.tgt_inv = 1'b1;
        step();
        chk("init_a_e4", st_a(), 4'b1000);

        // Minimal-timing switch on dut_b: enable low 2 cycles, busy 3
        chk("swb_e4", st_b(), 4'b0010);
        step();
        chk("swb_e5", st_b(), 4'b0110);
        step();
        chk("swb_e6", st_b(), 4'b1110);
        step();
        chk("swb_e7", st_b(), 4'b1101);
        step();
        chk("swb_e8", st_b(), 4'b1100);
        step();
        step();
        chki("no_done_init", done_a, 0);

        // Plain switch 0 -> 1 starting edge 11
        bus_a.tgt_inv = 1'b1;
        run_switch("sw_0to1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chki("sw1_edge", edge_n, 21);
        step();
        chk("idle_after_sw1", st_a(), 4'b1100);

        // Hold blocks a mismatched request, then release
        bus_a.sw_hold = 1'b1;
        bus_a.tgt_inv = 1'b0;
        repeat (20) begin
            step();
            chk("hold", st_a(), 4'b1100);
        end
        bus_a.sw_hold = 1'b0;
        run_switch("sw_hold_rel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_a.sw_hold = 1'b0;
        step();
        chk("idle_after_sw2", st_a(), 4'b1000);

        // Request pulse 0->1->0 during GATE, then back-to-back return switch
        bus_a.tgt_inv = 1'b1;
        run_switch("sw_pulse", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_switch("sw_back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("idle_after_sw4", st_a(), 4'b1000);
        chki("done_count", done_a, 4);

        // Reset in the middle of SWITCH with select already flipped
        bus_a.tgt_inv = 1'b1;
        repeat (5) step();
        chk("pre_rst", st_a(), 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a", st_a(), 4'b0010);
        chk("rst_mid_b", st_b(), 4'b0010);
        bus_a.tgt_inv = 1'b0;
        bus_b.tgt_inv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        edge_n = 0;
        step();
        chk("reinit_a_e1", st_a(), 4'b0010);
        chk("reinit_b_e1", st_b(), 4'b1000);
        step();
        step();
        chk("reinit_a_e3", st_a(), 4'b0010);
        step();
        chk("reinit_a_e4", st_a(), 4'b1000);
        step();
        chk("reinit_a_e5", st_a(), 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c3lib_ckinv_pol_ctl.md
Name: c3lib_ckinv_pol_ctl

Overview:
- Sequencer that switches a downstream clock path between true and inverted polarity without glitches.
- Drives the select of a true/inverted clock pair, built from a clock inverter cell plus a clock mux, and the enable of the following clock gate.
- Switch order: gate the clock off, change polarity, wait for the path to settle, re-enable the clock.
- Sits beside the c3lib clock primitives, in the clock-root logic of an AIB channel; runs on an always-on reference clock.

Parameters:
- GATE_CYC, 4, cycles ck_en is held low before the select changes (min 1).
- SETTLE_CYC, 2, cycles after the select change before ck_en is re-asserted (min 1).
- UNGATE_CYC, 4, cycles after ck_en rises before busy drops; also the post-reset wait before the first enable (min 1).
- RST_INV, 1'b0, reset value of ck_inv_sel.

Ports:
- clk  input  1  always-on reference clock
- rst_n  input  1  asynchronous active-low reset
- tgt_inv  input  1  requested polarity (1 = inverted path); level, synchronous to clk
- sw_hold  input  1  blocks the start of a new switch; does not abort one in progress
- ck_en  output  1  enable to the downstream clock gate
- ck_inv_sel  output  1  polarity select to the clock mux
- busy  output  1  high while initialising or switching
- sw_done  output  1  one-cycle pulse when a switch completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low: asserted asynchronously, released synchronously through an external synchroniser. All outputs are registered.
- Reset values: state=INIT, ck_en=0, ck_inv_sel=RST_INV, busy=1, sw_done=0, cnt=UNGATE_CYC-1.
- Down-counter: width CNT_W = $clog2(max(GATE_CYC,SETTLE_CYC,UNGATE_CYC)) (min 1). Each state loads it with N-1 on entry, decrements every cycle, and exits when cnt==0. Each state therefore lasts exactly N cycles.
- States and transitions:
  - INIT: on cnt==0, ck_en<=1, busy<=0, go to IDLE. ck_en first rises on the UNGATE_CYC-th rising edge after reset release.
  - IDLE: start condition is tgt_inv != ck_inv_sel && !sw_hold. On start: tgt_lat<=tgt_inv, ck_en<=0, busy<=1, cnt<=GATE_CYC-1, go to GATE.
  - GATE: on cnt==0, ck_inv_sel<=tgt_lat, cnt<=SETTLE_CYC-1, go to SWITCH.
  - SWITCH: on cnt==0, ck_en<=1, cnt<=UNGATE_CYC-1, go to UNGATE.
  - UNGATE: on cnt==0, busy<=0, sw_done<=1 for one cycle, go to IDLE.
- Timing per switch:
  - ck_en is low for exactly GATE_CYC+SETTLE_CYC cycles.
  - busy is high for GATE_CYC+SETTLE_CYC+UNGATE_CYC cycles (10 with defaults).
  - ck_inv_sel changes only while ck_en has been low for at least GATE_CYC cycles.
  - ck_inv_sel and ck_en never change on the same edge.
- tgt_inv changes during a switch: ignored. The target is latched on entry to GATE.
  - On return to IDLE the start condition is evaluated again. A mismatch starts a new switch on the next edge, sw_done and busy<=1 coincide on that cycle pair, and ck_en stays high for at least 1 cycle between switches.
  - A tgt_inv pulse that returns to ck_inv_sel before IDLE is reached causes no second switch.
- sw_hold: sampled only in IDLE. Asserted during GATE/SWITCH/UNGATE it has no effect.
- Reset mid-switch: all state returns to reset values immediately. ck_en=0 asynchronously, which is safe because it gates the clock off. ck_inv_sel snaps to RST_INV while gated, then INIT runs.
- No illegal states are reachable; the default branch goes to INIT with ck_en=0.

Decomposition:
- Package c3lib_ckctl_pkg:
  - state enum typedef ckpol_state_e {INIT, IDLE, GATE, SWITCH, UNGATE}, 3 bits.
  - function cnt_width(a,b,c) returning the clog2 of the maximum, shared with future clock-switch controllers.
- One natural sub-module: c3lib_ckctl_dcnt, a loadable down-counter with a zero flag, parameterised by width.
- The glitch-free mux and the inverter cell stay outside this block. This block only drives selects and enables.

Test Plan:
- Reset release, tgt_inv=RST_INV=0 -> ck_en=0 for cycles 0-3, rises at edge 4; busy falls with it; sw_done never pulses.
- After init, tgt_inv 0->1 at cycle 10 -> ck_en=0 from edge 11; ck_inv_sel=1 at edge 15; ck_en=1 at edge 17; sw_done pulse at edge 21; busy high edges 11-20.
- sw_hold=1 with tgt_inv mismatched for 20 cycles -> no output change. Drop sw_hold -> switch starts the next edge with the same timing as the previous scenario.
- tgt_inv toggles 0->1->0 during GATE -> sel goes to 1 and completes. Back in IDLE, mismatch -> second switch to 0 starts on the edge after sw_done; ck_en high exactly 1 cycle between the two switches.
- rst_n pulsed low during SWITCH with ck_inv_sel=1 -> ck_en=0 and ck_inv_sel=0 immediately, busy=1; INIT repeats and ck_en rises 4 edges after release.
- Param sweep GATE_CYC=1, SETTLE_CYC=1, UNGATE_CYC=1 -> ck_en low exactly 2 cycles, busy 3 cycles. Assertion holds that ck_inv_sel never changes while ck_en=1.
